// File: rtl/ctrl_pkg.sv
// ctrl_pkg: opcode/command encodings, branch types and the decoded control bundle.
package ctrl_pkg;
    localparam logic [5:0] OP_NOP  = 6'b000000;
    localparam logic [5:0] OP_ADD  = 6'b000001;
    localparam logic [5:0] OP_SUB  = 6'b000011;
    localparam logic [5:0] OP_AND  = 6'b000101;
    localparam logic [5:0] OP_OR   = 6'b000110;
    localparam logic [5:0] OP_NOR  = 6'b000111;
    localparam logic [5:0] OP_XOR  = 6'b001000;
    localparam logic [5:0] OP_SLA  = 6'b001001;
    localparam logic [5:0] OP_SLL  = 6'b001010;
    localparam logic [5:0] OP_SRA  = 6'b001011;
    localparam logic [5:0] OP_SRL  = 6'b001100;
    localparam logic [5:0] OP_ADDI = 6'b100000;
    localparam logic [5:0] OP_SUBI = 6'b100001;
    localparam logic [5:0] OP_LD   = 6'b100100;
    localparam logic [5:0] OP_ST   = 6'b100101;
    localparam logic [5:0] OP_BEZ  = 6'b101000;
    localparam logic [5:0] OP_BNE  = 6'b101001;
    localparam logic [5:0] OP_JMP  = 6'b101010;

    localparam logic [3:0] CMD_ADD = 4'b0000;
    localparam logic [3:0] CMD_SUB = 4'b0010;
    localparam logic [3:0] CMD_AND = 4'b0100;
    localparam logic [3:0] CMD_OR  = 4'b0101;
    localparam logic [3:0] CMD_NOR = 4'b0110;
    localparam logic [3:0] CMD_XOR = 4'b0111;
    localparam logic [3:0] CMD_SHL = 4'b1000;
    localparam logic [3:0] CMD_SRA = 4'b1001;
    localparam logic [3:0] CMD_SRL = 4'b1010;

    typedef enum logic [1:0] {BR_NONE, BR_BEZ, BR_BNE, BR_JMP} br_t;
    typedef enum logic {IDLE, SEQ} state_t;

    typedef struct packed {
        logic [3:0] cmd;
        logic       mem_r_en;
        logic       mem_w_en;
        logic       wb_en;
        logic       is_imm;
        br_t        br;
        logic       single_src;
        logic       illegal;
    } ctrl_t;

    function automatic ctrl_t mk(input logic [3:0] cmd, input logic r, input logic w,
                                 input logic wb, input logic imm, input br_t br, input logic ss);
        return '{cmd: cmd, mem_r_en: r, mem_w_en: w, wb_en: wb, is_imm: imm,
                 br: br, single_src: ss, illegal: 1'b0};
    endfunction
endpackage

// File: rtl/ctrl_decode.sv
// ctrl_decode: combinational opcode-to-control table; unknown opcodes decode as NOP with illegal set.
module ctrl_decode
    import ctrl_pkg::*;
#(
    parameter int OPC_W = 6
) (
    input  logic [OPC_W-1:0] opcode,
    output ctrl_t            ctrl
);
    always_comb begin
        ctrl = '0;
        case (opcode)
            OPC_W'(OP_NOP):  ctrl = mk(CMD_ADD, 0, 0, 0, 0, BR_NONE, 0);
            OPC_W'(OP_ADD):  ctrl = mk(CMD_ADD, 0, 0, 1, 0, BR_NONE, 0);
            OPC_W'(OP_SUB):  ctrl = mk(CMD_SUB, 0, 0, 1, 0, BR_NONE, 0);
            OPC_W'(OP_AND):  ctrl = mk(CMD_AND, 0, 0, 1, 0, BR_NONE, 0);
            OPC_W'(OP_OR):   ctrl = mk(CMD_OR,  0, 0, 1, 0, BR_NONE, 0);
            OPC_W'(OP_NOR):  ctrl = mk(CMD_NOR, 0, 0, 1, 0, BR_NONE, 0);
            OPC_W'(OP_XOR):  ctrl = mk(CMD_XOR, 0, 0, 1, 0, BR_NONE, 0);
            OPC_W'(OP_SLA),
            OPC_W'(OP_SLL):  ctrl = mk(CMD_SHL, 0, 0, 1, 0, BR_NONE, 0);
            OPC_W'(OP_SRA):  ctrl = mk(CMD_SRA, 0, 0, 1, 0, BR_NONE, 0);
            OPC_W'(OP_SRL):  ctrl = mk(CMD_SRL, 0, 0, 1, 0, BR_NONE, 0);
            OPC_W'(OP_ADDI): ctrl = mk(CMD_ADD, 0, 0, 1, 1, BR_NONE, 1);
            OPC_W'(OP_SUBI): ctrl = mk(CMD_SUB, 0, 0, 1, 1, BR_NONE, 1);
            OPC_W'(OP_LD):   ctrl = mk(CMD_ADD, 1, 0, 1, 1, BR_NONE, 1);
            OPC_W'(OP_ST):   ctrl = mk(CMD_ADD, 0, 1, 0, 1, BR_NONE, 0);
            OPC_W'(OP_BEZ):  ctrl = mk(CMD_ADD, 0, 0, 0, 1, BR_BEZ,  1);
            OPC_W'(OP_BNE):  ctrl = mk(CMD_ADD, 0, 0, 0, 1, BR_BNE,  0);
            OPC_W'(OP_JMP):  ctrl = mk(CMD_ADD, 0, 0, 0, 1, BR_JMP,  1);
            default:         ctrl.illegal = 1'b1;
        endcase
    end
endmodule

// File: rtl/ctrl_sequencer.sv
// ctrl_sequencer: ID-stage control with a multi-cycle SWP micro-sequencer, hazard bubbles and flush.
module ctrl_sequencer
    import ctrl_pkg::*;
#(
    parameter int               OPC_W        = 6,
    parameter int               CMD_W        = 4,
    parameter int               SWP_STEPS    = 2,
    parameter logic [CMD_W-1:0] SWP_CMD_BASE = 4'b1100,
    parameter logic [OPC_W-1:0] SWP_OPC      = 6'b111111
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [OPC_W-1:0]     opcode,
    input  logic                 valid,
    input  logic                 hazard,
    input  logic                 flush,
    output logic                 freeze,
    output logic [SWP_STEPS-1:0] swp_sel,
    output logic [CMD_W-1:0]     exec_cmd,
    output logic                 mem_r_en,
    output logic                 mem_w_en,
    output logic                 wb_en,
    output logic                 is_imm,
    output logic [1:0]           branch_type,
    output logic                 single_src,
    output logic                 busy,
    output logic                 illegal
);
    localparam int STEP_W = $clog2(SWP_STEPS);
    localparam logic [STEP_W-1:0] LAST = STEP_W'(SWP_STEPS - 1);

    state_t            state, state_nx;
    logic [STEP_W-1:0] step, step_nx;
    ctrl_t             dec;
    logic              is_swp, run, last;

    ctrl_decode #(.OPC_W(OPC_W)) u_decode (.opcode(opcode), .ctrl(dec));

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            step  <= '0;
        end else begin
            state <= state_nx;
            step  <= step_nx;
        end
    end

    // SEQ advances on valid=0 too: valid is held constant while IF/ID is frozen.
    always_comb begin
        state_nx = state;
        step_nx  = step;
        last     = step == LAST;
        is_swp   = state == SEQ || opcode == SWP_OPC;
        run      = !rst && !flush && !hazard && valid;
        if (flush) begin
            state_nx = IDLE;
            step_nx  = '0;
        end else if (!hazard) begin
            if (state == SEQ) begin
                state_nx = last ? IDLE : SEQ;
                step_nx  = last ? '0 : step + STEP_W'(1);
            end else if (valid && opcode == SWP_OPC) begin
                state_nx = SEQ;
                step_nx  = STEP_W'(1);
            end
        end
        exec_cmd    = !run ? '0 : is_swp ? SWP_CMD_BASE + CMD_W'(step) : CMD_W'(dec.cmd);
        swp_sel     = (run && is_swp) ? SWP_STEPS'(1) << step : '0;
        freeze      = run && is_swp && !last;
        wb_en       = run && (is_swp || dec.wb_en);
        mem_r_en    = run && !is_swp && dec.mem_r_en;
        mem_w_en    = run && !is_swp && dec.mem_w_en;
        is_imm      = run && !is_swp && dec.is_imm;
        branch_type = (run && !is_swp) ? dec.br : BR_NONE;
        single_src  = run && !is_swp && dec.single_src;
        illegal     = run && !is_swp && dec.illegal;
        busy        = !rst && !flush && valid && state == SEQ;
    end
endmodule
